bc_scheduler: RTL and testbench
===============================

Name: bc_scheduler

Overview:
- Controller and arbiter for the shared datapath_BC bit-counter datapath.
- Accepts popcount requests from NUM_REQ requesters and selects one by round-robin.
- Sequences the datapath's load_b, result_shift and done strobes, then returns the 1's count with a valid/ack response handshake.
- Sits between the requesting blocks and the single datapath_BC instance; the datapath keeps its own reset tied to the same reset.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- WIDTH, 8, data width per request; must match the datapath width; legal range 1..15, so the count fits the 4-bit result.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- req  input  NUM_REQ  per-requester request level; held until the matching gnt bit.
- req_data  input  NUM_REQ*WIDTH  flattened request data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  NUM_REQ  one-hot one-cycle pulse marking the captured request.
- busy  output  1  high whenever state != IDLE.
- dp_A  output  WIDTH  data to datapath A; registered copy of the winner's data.
- load_b  output  1  datapath load strobe.
- result_shift  output  1  datapath shift enable.
- done  output  1  datapath result enable.
- z  input  1  datapath zero flag (remaining data == 0).
- dp_result  input  4  datapath count; valid only while done=1.
- rsp_valid  output  1  response valid.
- rsp_id  output  $clog2(NUM_REQ)  index of the requester the response belongs to.
- rsp_count  output  4  number of 1's in that requester's data.
- rsp_ack  input  1  consumer accepts the response.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, data_q=0, id_q=0, rsp_count=0; all outputs 0. Reset mid-operation aborts the job with no response, and gnt is never re-issued for the aborted job. The datapath resets in the same cycle.
- IDLE:
  - If |req, the arbiter picks the first set req bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - On that edge: id_q<=winner, data_q<=winner's req_data slice, rr_ptr<=(winner+1) mod NUM_REQ, go to LOAD.
  - No request: stay in IDLE.
- LOAD, one cycle: gnt[id_q]=1, load_b=1, dp_A=data_q; go to SHIFT unconditionally.
- SHIFT:
  - z=0: result_shift=1, stay in SHIFT.
  - z=1: result_shift=0, go to DONE.
  - Number of shifting cycles s = index of data MSB set + 1; s=0 for zero data, giving one SHIFT cycle with z=1.
- DONE, one cycle: done=1; rsp_count<=dp_result, rsp_id<=id_q; go to RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_count are held stable.
  - rsp_ack=1: go to IDLE on that edge. Otherwise stay.
  - No new arbitration in RESP; requests arriving meanwhile wait.
- Latency: req sampled in IDLE cycle t0; gnt at t0+1; rsp_valid first asserted at t0+4+s. Back-to-back jobs are separated by at least one IDLE cycle.
- Strobe rules:
  - load_b, result_shift and done are mutually exclusive and are decoded only from the state register (plus z in SHIFT).
  - dp_A holds data_q in every state.
- Boundary conditions:
  - All req set: strict rotation 0,1,2,...,NUM_REQ-1,0.
  - A requester that drops req before gnt is simply not selected.
  - rsp_ack asserted outside RESP is ignored.
  - A requester whose req bit is still high after its own gnt is treated as a new request.

Decomposition:
- bc_pkg: typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, RESP} bc_state_t; localparam CNT_W=4.
- Sub-module bc_rr_arbiter (combinational):
  - Inputs: req, rr_ptr.
  - Outputs: any_req, winner index.
  - Implemented as a rotate-priority search.
- Top-level bc_scheduler contains the FSM, data/id registers, rr_ptr and the response registers. The bench instantiates bc_scheduler together with datapath_BC.

Test Plan:
- Reset, then req=4'b0001 with data 8'b01100111, rsp_ack held 1 -> gnt=4'b0001 one cycle; 7 result_shift cycles; rsp_valid at t0+11 with rsp_id=0, rsp_count=5.
- req[2] with data 8'b11000011 -> 8 shift cycles, rsp_count=4, rsp_id=2. Then data 8'h00 on req[1] -> 1 SHIFT cycle, rsp_count=0, rsp_valid at t0+4.
- req=4'b1111 held, rsp_ack=1 -> gnt order 0,1,2,3,0; rr_ptr wraps correctly.
- rsp_ack held 0 for 5 cycles with req[3] pending -> rsp_valid, rsp_id and rsp_count are stable and gnt[3] is not issued; ack -> IDLE, then gnt[3].
- Reset asserted during SHIFT -> next cycle all outputs 0 and state IDLE with no rsp_valid; rr_ptr=0, so req=4'b1010 is granted to 1.
- Data 8'b10000000 on req[0] -> exactly 8 result_shift cycles, rsp_count=1; done is high exactly one cycle and never overlaps load_b or result_shift.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared types and constants for the bit-counter scheduler and its datapath.
package bc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE,
        RESP
    } bc_state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/bc_scheduler_if.sv
// Requester/consumer side of the scheduler: request levels, data, grants and the response handshake.
interface bc_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    import bc_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       gnt;
    logic                     rsp_valid;
    logic [IDW-1:0]           rsp_id;
    logic [CNT_W-1:0]         rsp_count;
    logic                     rsp_ack;

    modport slave (
        input  req, req_data, rsp_ack,
        output gnt, rsp_valid, rsp_id, rsp_count
    );

    modport master (
        output req, req_data, rsp_ack,
        input  gnt, rsp_valid, rsp_id, rsp_count
    );

endinterface

// File: rtl/bc_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping modulo NUM_REQ.
module bc_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       any_req,
    output logic [$clog2(NUM_REQ)-1:0] winner
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW:0] idx;
    logic         found;

    assign any_req = |req;

    // One extra bit on idx so rr_ptr+k never overflows before the modulo fold.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_REQ)) begin
                idx = idx - (IDW+1)'(NUM_REQ);
            end
            if (!found && req[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/datapath_BC.sv
// Shared bit-counter datapath: load, shift right while counting LSB ones, expose count on done.
module datapath_BC
    import bc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic             load_b,
    input  logic             result_shift,
    input  logic             done,
    output logic             z,
    output logic [CNT_W-1:0] result
);
    logic [WIDTH-1:0] a_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg   <= '0;
            cnt_reg <= '0;
        end else if (load_b) begin
            a_reg   <= A;
            cnt_reg <= '0;
        end else if (result_shift) begin
            a_reg   <= a_reg >> 1;
            cnt_reg <= cnt_reg + CNT_W'(a_reg[0]);
        end
    end

    assign z      = (a_reg == '0);
    assign result = done ? cnt_reg : '0;

endmodule

// File: rtl/bc_scheduler.sv
// Round-robin front end for datapath_BC: captures one request, sequences the datapath, returns the count.
module bc_scheduler
    import bc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic             clk,
    input  logic             reset,
    bc_scheduler_if.slave    bus,
    output logic             busy,
    output logic [WIDTH-1:0] dp_A,
    output logic             load_b,
    output logic             result_shift,
    output logic             done,
    input  logic             z,
    input  logic [CNT_W-1:0] dp_result
);
    localparam int IDW = $clog2(NUM_REQ);

    bc_state_t        state_reg;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [IDW-1:0]   id_reg;
    logic [IDW-1:0]   rsp_id_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] rsp_count_reg;
    logic             any_req;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   rr_ptr_next;
    logic [WIDTH-1:0] req_slice [NUM_REQ];

    bc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (bus.req),
        .rr_ptr  (rr_ptr_reg),
        .any_req (any_req),
        .winner  (winner)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_slice[gi] = bus.req_data[gi*WIDTH +: WIDTH];
            assign bus.gnt[gi]   = (state_reg == LOAD) && (id_reg == IDW'(gi));
        end
    endgenerate

    assign rr_ptr_next = (winner == IDW'(NUM_REQ-1)) ? '0 : winner + IDW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            id_reg        <= '0;
            data_reg      <= '0;
            rsp_id_reg    <= '0;
            rsp_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        id_reg     <= winner;
                        data_reg   <= req_slice[winner];
                        rr_ptr_reg <= rr_ptr_next;
                        state_reg  <= LOAD;
                    end
                end
                LOAD:  state_reg <= SHIFT;
                SHIFT: if (z) state_reg <= DONE;
                DONE: begin
                    rsp_count_reg <= dp_result;
                    rsp_id_reg    <= id_reg;
                    state_reg     <= RESP;
                end
                // New requests wait here until the consumer takes the response.
                RESP:  if (bus.rsp_ack) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy          = (state_reg != IDLE);
    assign dp_A          = data_reg;
    assign load_b        = (state_reg == LOAD);
    assign result_shift  = (state_reg == SHIFT) && !z;
    assign done          = (state_reg == DONE);
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_count = rsp_count_reg;

endmodule

// File: tb/tb_bc_scheduler.sv
// Directed bench for bc_scheduler driving a real datapath_BC; one task per scenario.
module tb_bc_scheduler;
    import bc_pkg::*;

    localparam int NR = 4;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         busy, load_b, result_shift, done, z;
    logic [W-1:0] dp_A;
    logic [3:0]   dp_result;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    bc_scheduler_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    bc_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .busy         (busy),
        .dp_A         (dp_A),
        .load_b       (load_b),
        .result_shift (result_shift),
        .done         (done),
        .z            (z),
        .dp_result    (dp_result)
    );

    datapath_BC #(.WIDTH(W)) dp (
        .clk          (clk),
        .reset        (reset),
        .A            (dp_A),
        .load_b       (load_b),
        .result_shift (result_shift),
        .done         (done),
        .z            (z),
        .result       (dp_result)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] d);
        bus.req_data[i*W +: W] = d;
    endtask

    // Runs one job from an IDLE cycle (t0) and reports what was observed; cycle numbers are relative to t0.
    task automatic run_job(input logic [3:0] rv, output logic [3:0] g, output int gcyc, output int gcnt,
                           output int shifts, output int dones, output int ovl, output int rcyc,
                           output logic [1:0] rid, output logic [3:0] rcnt);
        g = '0; gcyc = -1; gcnt = 0; shifts = 0; dones = 0; ovl = 0; rcyc = -1; rid = '0; rcnt = '0;
        bus.req = rv;
        for (int c = 1; c <= 60; c++) begin
            tick;
            if (bus.gnt != 4'b0000) begin
                gcnt++;
                if (gcyc < 0) begin
                    gcyc = c;
                    g    = bus.gnt;
                end
                bus.req = bus.req & ~bus.gnt;
            end
            if (result_shift) shifts++;
            if (done) dones++;
            if (int'(load_b) + int'(result_shift) + int'(done) > 1) ovl++;
            if (bus.rsp_valid) begin
                rcyc = c;
                rid  = bus.rsp_id;
                rcnt = bus.rsp_count;
                break;
            end
        end
    endtask

    task automatic wait_idle;
        for (int c = 0; c < 60 && busy; c++) tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b want 0 within 60 cycles", busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.req = '0; bus.req_data = '0; bus.rsp_ack = 1'b0;
        tick; tick;
        checks++;
        if ({busy, load_b, result_shift, done, bus.gnt, bus.rsp_valid, bus.rsp_id, bus.rsp_count, dp_A} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b ld=%b sh=%b dn=%b gnt=%b vld=%b id=%0d cnt=%0d A=%h want all 0",
                     busy, load_b, result_shift, done, bus.gnt, bus.rsp_valid, bus.rsp_id, bus.rsp_count, dp_A);
        end
        reset = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic;
        logic [3:0] g, rcnt; logic [1:0] rid; int gcyc, gcnt, sh, dn, ovl, rcyc;
        bus.rsp_ack = 1'b1;
        set_data(0, 8'b01100111);
        run_job(4'b0001, g, gcyc, gcnt, sh, dn, ovl, rcyc, rid, rcnt);
        checks++; if (g !== 4'b0001 || gcyc != 1 || gcnt != 1) begin errors++;
            $display("FAIL basic_gnt: gnt=%b at %0d x%0d want 0001 at 1 x1", g, gcyc, gcnt); end
        checks++; if (sh != 7) begin errors++; $display("FAIL basic_shifts: got %0d want 7", sh); end
        checks++; if (rcyc != 11) begin errors++; $display("FAIL basic_latency: got %0d want 11", rcyc); end
        checks++; if (rid !== 2'd0 || rcnt !== 4'd5) begin errors++;
            $display("FAIL basic_rsp: id=%0d cnt=%0d want id=0 cnt=5", rid, rcnt); end
        tick;
        checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++;
            $display("FAIL basic_ack_idle: busy=%b vld=%b want 0 0", busy, bus.rsp_valid); end
    endtask

    task automatic test_patterns;
        logic [3:0] g, rcnt; logic [1:0] rid; int gcyc, gcnt, sh, dn, ovl, rcyc;
        set_data(2, 8'b11000011);
        run_job(4'b0100, g, gcyc, gcnt, sh, dn, ovl, rcyc, rid, rcnt);
        checks++; if (g !== 4'b0100 || sh != 8 || rcyc != 12) begin errors++;
            $display("FAIL pat_c3_timing: gnt=%b sh=%0d rsp@%0d want 0100 8 12", g, sh, rcyc); end
        checks++; if (rid !== 2'd2 || rcnt !== 4'd4) begin errors++;
            $display("FAIL pat_c3_rsp: id=%0d cnt=%0d want 2 4", rid, rcnt); end
        tick;
        set_data(1, 8'h00);
        run_job(4'b0010, g, gcyc, gcnt, sh, dn, ovl, rcyc, rid, rcnt);
        checks++; if (g !== 4'b0010 || sh != 0 || rcyc != 4) begin errors++;
            $display("FAIL pat_zero_timing: gnt=%b sh=%0d rsp@%0d want 0010 0 4", g, sh, rcyc); end
        checks++; if (rid !== 2'd1 || rcnt !== 4'd0) begin errors++;
            $display("FAIL pat_zero_rsp: id=%0d cnt=%0d want 1 0", rid, rcnt); end
        tick;
    endtask

    task automatic test_rotation;
        logic [3:0] seen [5];
        logic [3:0] exp_ord [5];
        int n;
        exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        n = 0;
        reset = 1'b1; tick; reset = 1'b0;
        set_data(0, 8'h01); set_data(1, 8'h03); set_data(2, 8'h0F); set_data(3, 8'h80);
        bus.rsp_ack = 1'b1;
        bus.req = 4'b1111;
        for (int c = 0; c < 150 && n < 5; c++) begin
            tick;
            if (bus.gnt != 4'b0000) begin
                seen[n] = bus.gnt;
                n++;
            end
        end
        bus.req = 4'b0000;
        checks++; if (n != 5) begin errors++; $display("FAIL rot_count: got %0d grants want 5", n); end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (seen[k] !== exp_ord[k]) begin errors++;
                $display("FAIL rot_order[%0d]: got %b want %b", k, seen[k], exp_ord[k]); end
        end
        wait_idle;
    endtask

    task automatic test_ack_hold;
        logic [3:0] g, rcnt; logic [1:0] rid; int gcyc, gcnt, sh, dn, ovl, rcyc;
        bus.rsp_ack = 1'b0;
        set_data(1, 8'b00000101);
        set_data(3, 8'hFF);
        run_job(4'b1010, g, gcyc, gcnt, sh, dn, ovl, rcyc, rid, rcnt);
        checks++; if (g !== 4'b0010 || rcyc != 7 || rid !== 2'd1 || rcnt !== 4'd2) begin errors++;
            $display("FAIL hold_first: gnt=%b rsp@%0d id=%0d cnt=%0d want 0010 7 1 2", g, rcyc, rid, rcnt); end
        for (int c = 0; c < 5; c++) begin
            tick;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_count !== 4'd2) begin errors++;
                $display("FAIL hold_stable[%0d]: vld=%b id=%0d cnt=%0d want 1 1 2", c, bus.rsp_valid, bus.rsp_id, bus.rsp_count); end
            checks++;
            if (bus.gnt !== 4'b0000) begin errors++;
                $display("FAIL hold_no_gnt[%0d]: gnt=%b want 0000", c, bus.gnt); end
        end
        bus.rsp_ack = 1'b1;
        tick;
        checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++;
            $display("FAIL hold_release: busy=%b vld=%b want 0 0", busy, bus.rsp_valid); end
        tick;
        checks++; if (bus.gnt !== 4'b1000) begin errors++;
            $display("FAIL hold_next_gnt: gnt=%b want 1000", bus.gnt); end
        bus.req = 4'b0000;
        wait_idle;
    endtask

    task automatic test_reset_mid;
        set_data(2, 8'hFF);
        bus.req = 4'b0100;
        tick;
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL mid_gnt: got %b want 0100", bus.gnt); end
        bus.req = 4'b0000;
        tick;
        checks++; if (result_shift !== 1'b1) begin errors++; $display("FAIL mid_shifting: got %b want 1", result_shift); end
        reset = 1'b1;
        tick;
        checks++;
        if ({busy, load_b, result_shift, done, bus.gnt, bus.rsp_valid, bus.rsp_id, bus.rsp_count, dp_A} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b ld=%b sh=%b dn=%b gnt=%b vld=%b id=%0d cnt=%0d A=%h want all 0",
                     busy, load_b, result_shift, done, bus.gnt, bus.rsp_valid, bus.rsp_id, bus.rsp_count, dp_A);
        end
        reset = 1'b0;
        set_data(1, 8'h01);
        bus.req = 4'b1010;
        tick;
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL mid_rrptr_cleared: gnt=%b want 0010", bus.gnt); end
        bus.req = 4'b0000;
        wait_idle;
    endtask

    task automatic test_msb;
        logic [3:0] g, rcnt; logic [1:0] rid; int gcyc, gcnt, sh, dn, ovl, rcyc;
        bus.rsp_ack = 1'b1;
        set_data(0, 8'b10000000);
        run_job(4'b0001, g, gcyc, gcnt, sh, dn, ovl, rcyc, rid, rcnt);
        checks++; if (g !== 4'b0001 || sh != 8 || rcyc != 12) begin errors++;
            $display("FAIL msb_timing: gnt=%b sh=%0d rsp@%0d want 0001 8 12", g, sh, rcyc); end
        checks++; if (dn != 1 || ovl != 0) begin errors++;
            $display("FAIL msb_strobes: done_cycles=%0d overlaps=%0d want 1 0", dn, ovl); end
        checks++; if (rid !== 2'd0 || rcnt !== 4'd1) begin errors++;
            $display("FAIL msb_rsp: id=%0d cnt=%0d want 0 1", rid, rcnt); end
        tick;
    endtask

    task automatic test_drop_before_gnt;
        set_data(0, 8'h01);
        bus.req = 4'b0001;
        tick;
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL drop_gnt0: got %b want 0001", bus.gnt); end
        bus.req = 4'b0100;
        tick; tick; tick;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL drop_done: got %b want 1", done); end
        bus.req = 4'b0000;
        tick;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_count !== 4'd1) begin errors++;
            $display("FAIL drop_rsp: vld=%b cnt=%0d want 1 1", bus.rsp_valid, bus.rsp_count); end
        tick; tick;
        checks++; if (busy !== 1'b0 || bus.gnt !== 4'b0000) begin errors++;
            $display("FAIL drop_not_selected: busy=%b gnt=%b want 0 0000", busy, bus.gnt); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_patterns;
        test_rotation;
        test_ack_hold;
        test_reset_mid;
        test_msb;
        test_drop_before_gnt;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 want finished");
        $fatal(1, "watchdog");
    end

endmodule
